peripheral_putresult: RTL and testbench
=======================================

Name: peripheral_putresult

Overview:
Byte-serializing output stage for the peripherals unit. It is the opposite direction of operand capture: operand capture gathers 8-bit keyed bytes into 32-bit words, and this block does the reverse. It takes a full result word from the datapath and presents it one byte at a time, LSB first. Each byte carries its index and a valid/ready handshake, so a display or host stage can consume it. Consumption can be driven by a downstream ready signal or stepped manually by the debounced enter pulse.

Parameters:
NBYTES, 4, number of bytes per word (>= 2); the word width is NBYTES*8.
IDXW, 2, index width; must equal clog2(NBYTES).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
load  input  1  single-cycle strobe; capture datain and start a transfer.
datain  input  NBYTES*8  word to serialize (e.g. dataR).
manual  input  1  1 = advance on step; 0 = advance on out_ready. Sampled every cycle.
step  input  1  single-cycle pulse from the pulse generator (enter button).
out_ready  input  1  downstream accepts the current byte.
clear  input  1  synchronous abort of the current transfer.
out_byte  output  8  current byte.
out_idx  output  IDXW  index of the current byte (0 = LSB).
out_valid  output  1  out_byte/out_idx are valid.
busy  output  1  a transfer is in progress.
done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, out_byte=0, out_idx=0, out_valid=0, busy=0, done=0. Takes effect immediately, including mid-transfer. No done is produced.
- States: IDLE, SEND.
- IDLE:
  - out_valid=0, busy=0.
  - load=1 captures datain into the internal word, sets out_idx=0 and out_byte=datain[7:0], and enters SEND.
  - out_valid=1 and busy=1 from the next cycle. Latency from load to valid is 1 cycle.
- SEND:
  - out_valid=1, busy=1.
  - adv = manual ? step : out_ready. A beat is accepted on a rising edge where out_valid=1 and adv=1.
  - out_byte and out_idx must hold stable until accepted.
  - Accept with out_idx < NBYTES-1: out_idx+1, out_byte = next byte (word[(idx+1)*8 +: 8]), out_valid stays 1. This allows back-to-back one byte per cycle with out_ready held high.
  - Accept with out_idx = NBYTES-1: go to IDLE, out_valid=0, busy=0, out_idx=0, done=1 for exactly the next cycle.
- load while in SEND is ignored; the captured word and index are unchanged.
- load in the cycle where done=1 (state already IDLE) is accepted normally.
- clear=1 in any state: next cycle is IDLE with out_valid=0, busy=0, out_idx=0, done=0.
  - clear has priority over load and over beat acceptance in the same cycle.
  - The captured word is not zeroed by clear.
- Changing manual mid-transfer takes effect on the next acceptance decision; no byte is skipped or duplicated.
- A step pulse in IDLE, or in SEND with manual=0, has no effect. out_ready is ignored when manual=1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then load with datain=0xA1B2C3D4, manual=0, out_ready=1 → next cycle out_valid=1, out_idx=0, out_byte=0xD4. Then one byte per cycle: 0xC3/1, 0xB2/2, 0xA1/3; then out_valid=0 and done=1 for one cycle; busy high for exactly 4 cycles.
- Backpressure: manual=0, out_ready toggling 0,0,1,0,1,1,1 after load of 0x11223344 → each byte held stable while out_ready=0; bytes 0x44, 0x33, 0x22, 0x11 each emitted exactly once, in order.
- Manual mode: manual=1, out_ready=1 constant, four step pulses spaced 5 cycles apart after load of 0xDEADBEEF → out_idx advances only on step (0xEF, 0xBE, 0xAD, 0xDE); done follows the 4th step.
- Second load of 0xFFFFFFFF at idx=2 during a transfer of 0x01020304 → ignored; remaining bytes 0x02, 0x01 are emitted.
- clear asserted together with an accepting out_ready at idx=1 → IDLE next cycle, out_valid=0, done never asserts. A subsequent load of 0x55AA55AA restarts at idx=0 with byte 0xAA.
- reset driven low at idx=2 mid-transfer, asynchronously between edges → outputs go to reset values immediately, before the next clock edge; no done pulse.

Source files
------------

// File: rtl/peripheral_putresult_if.sv
// Byte-stream handshake bundle for the result serializer: word load/abort
// controls on the input side, byte/index/valid plus status on the output side.
interface peripheral_putresult_if #(
  parameter int NBYTES = 4,
  parameter int IDXW   = 2
);
  logic                  load;
  logic [NBYTES*8-1:0]   datain;
  logic                  manual;
  logic                  step;
  logic                  out_ready;
  logic                  clear;
  logic [7:0]            out_byte;
  logic [IDXW-1:0]       out_idx;
  logic                  out_valid;
  logic                  busy;
  logic                  done;

  // Serializer side
  modport slave (
    input  load, datain, manual, step, out_ready, clear,
    output out_byte, out_idx, out_valid, busy, done
  );

  // Datapath / consumer side
  modport master (
    output load, datain, manual, step, out_ready, clear,
    input  out_byte, out_idx, out_valid, busy, done
  );
endinterface

// File: rtl/peripheral_putresult.sv
// Result word serializer: captures a NBYTES*8-bit word on load and presents
// it one byte at a time, LSB first, with index and valid/ready handshake.
// Advance comes from out_ready, or from the debounced step pulse in manual
// mode. All outputs come straight from registers.
module peripheral_putresult #(
  parameter int NBYTES = 4,
  parameter int IDXW   = 2
) (
  input  logic clk,
  input  logic reset,
  peripheral_putresult_if.slave bus
);

  localparam int              W    = NBYTES * 8;
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic            valid_q, valid_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            adv;

  // Next-state logic: clear dominates, then load (IDLE) or beat accept (SEND).
  // The current byte is always the low byte of the shift register, so the
  // "next byte" on accept is simply the word shifted down by 8.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adv     = bus.manual ? bus.step : bus.out_ready;

    if (bus.clear) begin
      state_d = IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            state_d = SEND;
            shift_d = bus.datain;
            idx_d   = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        SEND: begin
          if (valid_q && adv) begin
            if (idx_q == LAST) begin
              state_d = IDLE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              shift_d = {8'h00, shift_q[W-1:8]};
              idx_d   = idx_q + IDXW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_byte  = shift_q[7:0];
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_peripheral_putresult.sv
// Directed bench for peripheral_putresult: reset, streaming, backpressure,
// manual stepping, ignored reload, clear abort and asynchronous reset.
module tb_peripheral_putresult;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  peripheral_putresult_if #(.NBYTES(4), .IDXW(2)) bus ();

  peripheral_putresult #(.NBYTES(4), .IDXW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests++;
    if (bus.out_idx !== 2'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", bus.out_idx); end
    tests++;
    if (bus.out_byte !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h want 00", bus.out_byte); end
    tests++;
  endtask

  task automatic test_stream();
    logic [7:0] eb [4];
    int busy_cnt;
    eb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    busy_cnt = 0;
    bus.manual = 1'b0; bus.out_ready = 1'b1;
    bus.datain = 32'hA1B2C3D4; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid); end
      tests++;
      if (bus.out_idx !== 2'(i)) begin fails++; $display("FAIL stream_idx[%0d]: got %0d want %0d", i, bus.out_idx, i); end
      tests++;
      if (bus.out_byte !== eb[i]) begin fails++; $display("FAIL stream_byte[%0d]: got %h want %h", i, bus.out_byte, eb[i]); end
      tests++;
      if (bus.done !== 1'b0) begin fails++; $display("FAIL stream_early_done[%0d]: got %b want 0", i, bus.done); end
      tests++;
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
    end
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_end_valid: got %b want 0", bus.out_valid); end
    tests++;
    if (bus.done !== 1'b1) begin fails++; $display("FAIL stream_done: got %b want 1", bus.done); end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL stream_end_busy: got %b want 0", bus.busy); end
    tests++;
    if (busy_cnt != 4) begin fails++; $display("FAIL stream_busy_cycles: got %0d want 4", busy_cnt); end
    tests++;
    // load in the done cycle is accepted
    bus.out_ready = 1'b0; bus.datain = 32'h8899AABB; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL done_width: got %b want 0", bus.done); end
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd0 || bus.out_byte !== 8'hBB) begin
      fails++; $display("FAIL load_on_done: got v=%b i=%0d b=%h want v=1 i=0 b=bb", bus.out_valid, bus.out_idx, bus.out_byte);
    end
    tests++;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    if (bus.done !== 1'b1) begin fails++; $display("FAIL load_on_done_finish: got %b want 1", bus.done); end
    tests++;
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] eb [4];
    logic       pat [7];
    int n;
    eb  = '{8'h44, 8'h33, 8'h22, 8'h11};
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    n = 0;
    bus.manual = 1'b0; bus.out_ready = 1'b0;
    bus.datain = 32'h11223344; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 1", k, bus.out_valid); end
      tests++;
      if (bus.out_idx !== 2'(n) || bus.out_byte !== eb[n]) begin
        fails++; $display("FAIL bp_hold[%0d]: got i=%0d b=%h want i=%0d b=%h", k, bus.out_idx, bus.out_byte, n, eb[n]);
      end
      tests++;
      bus.out_ready = pat[k];
      if (pat[k]) n++;
      tick();
    end
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b1) begin
      fails++; $display("FAIL bp_end: got v=%b d=%b want v=0 d=1", bus.out_valid, bus.done);
    end
    tests++;
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_manual();
    logic [7:0] eb [4];
    eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    // step in IDLE does nothing
    bus.manual = 1'b0; bus.out_ready = 1'b0; bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL step_idle: got v=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    tests++;
    bus.datain = 32'hDEADBEEF; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    // step with manual=0 does nothing
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    if (bus.out_idx !== 2'd0 || bus.out_byte !== 8'hEF) begin
      fails++; $display("FAIL step_auto_mode: got i=%0d b=%h want i=0 b=ef", bus.out_idx, bus.out_byte);
    end
    tests++;
    bus.manual = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) begin
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'(i) || bus.out_byte !== eb[i]) begin
          fails++; $display("FAIL manual_hold[%0d]: got v=%b i=%0d b=%h want v=1 i=%0d b=%h", i, bus.out_valid, bus.out_idx, bus.out_byte, i, eb[i]);
        end
        tests++;
        tick();
      end
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
    end
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b1) begin
      fails++; $display("FAIL manual_done: got v=%b d=%b want v=0 d=1", bus.out_valid, bus.done);
    end
    tests++;
    bus.manual = 1'b0; bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_load_ignored();
    bus.manual = 1'b0; bus.out_ready = 1'b1;
    bus.datain = 32'h01020304; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    if (bus.out_idx !== 2'd2 || bus.out_byte !== 8'h02) begin
      fails++; $display("FAIL reload_pre: got i=%0d b=%h want i=2 b=02", bus.out_idx, bus.out_byte);
    end
    tests++;
    bus.out_ready = 1'b0; bus.datain = 32'hFFFFFFFF; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2 || bus.out_byte !== 8'h02) begin
      fails++; $display("FAIL reload_ignored: got v=%b i=%0d b=%h want v=1 i=2 b=02", bus.out_valid, bus.out_idx, bus.out_byte);
    end
    tests++;
    bus.out_ready = 1'b1;
    tick();
    if (bus.out_idx !== 2'd3 || bus.out_byte !== 8'h01) begin
      fails++; $display("FAIL reload_last: got i=%0d b=%h want i=3 b=01", bus.out_idx, bus.out_byte);
    end
    tests++;
    tick();
    if (bus.done !== 1'b1) begin fails++; $display("FAIL reload_done: got %b want 1", bus.done); end
    tests++;
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    bus.manual = 1'b0; bus.out_ready = 1'b1;
    bus.datain = 32'h0A0B0C0D; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    if (bus.out_idx !== 2'd1 || bus.out_byte !== 8'h0C) begin
      fails++; $display("FAIL clear_pre: got i=%0d b=%h want i=1 b=0c", bus.out_idx, bus.out_byte);
    end
    tests++;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_idx !== 2'd0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL clear_idle: got v=%b busy=%b i=%0d d=%b want 0 0 0 0", bus.out_valid, bus.busy, bus.out_idx, bus.done);
    end
    tests++;
    repeat (3) begin
      tick();
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL clear_no_done: got d=%b v=%b want 0 0", bus.done, bus.out_valid);
      end
      tests++;
    end
    bus.out_ready = 1'b0; bus.datain = 32'h55AA55AA; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd0 || bus.out_byte !== 8'hAA) begin
      fails++; $display("FAIL clear_restart: got v=%b i=%0d b=%h want v=1 i=0 b=aa", bus.out_valid, bus.out_idx, bus.out_byte);
    end
    tests++;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    if (bus.done !== 1'b1) begin fails++; $display("FAIL clear_restart_done: got %b want 1", bus.done); end
    tests++;
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.manual = 1'b0; bus.out_ready = 1'b1;
    bus.datain = 32'h12345678; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b0;
    if (bus.out_idx !== 2'd2 || bus.out_byte !== 8'h34) begin
      fails++; $display("FAIL areset_pre: got i=%0d b=%h want i=2 b=34", bus.out_idx, bus.out_byte);
    end
    tests++;
    #2 reset = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.out_idx !== 2'd0 || bus.out_byte !== 8'h00) begin
      fails++; $display("FAIL areset_immediate: got v=%b busy=%b d=%b i=%0d b=%h want all 0",
                        bus.out_valid, bus.busy, bus.done, bus.out_idx, bus.out_byte);
    end
    tests++;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      tick();
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL areset_no_done: got d=%b v=%b want 0 0", bus.done, bus.out_valid);
      end
      tests++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.load = 1'b0; bus.datain = '0; bus.manual = 1'b0;
    bus.step = 1'b0; bus.out_ready = 1'b0; bus.clear = 1'b0;
    #2 reset = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_manual();
    test_load_ignored();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
